// File: rtl/lcm_datapath_if.sv
// rtl/lcm_datapath_if.sv - command/readback bundle for the lcm datapath
interface lcm_datapath_if;
  logic [3:0]  raddr1;
  logic [3:0]  raddr2;
  logic        wen;
  logic [3:0]  waddr;
  logic        wdsrc;
  logic [3:0]  func;
  logic [31:0] constant;
  logic        alusrc;
  logic [31:0] aluconst;
  logic [31:0] outrdata1;
  logic [31:0] outrdata2;
  logic        isZero;
  logic        busy;
  logic        drop;

  modport master (
    output raddr1, raddr2, wen, waddr, wdsrc, func, constant, alusrc, aluconst,
    input  outrdata1, outrdata2, isZero, busy, drop
  );

  modport slave (
    input  raddr1, raddr2, wen, waddr, wdsrc, func, constant, alusrc, aluconst,
    output outrdata1, outrdata2, isZero, busy, drop
  );
endinterface

// File: rtl/lcm_datapath.sv
// rtl/lcm_datapath.sv - 16x32 register file, single-cycle ALU and 33-cycle MOD unit
module lcm_datapath (
  input logic           clk,
  input logic           rst,
  lcm_datapath_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, WB} state_t;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_XOR   = 4'd4;
  localparam logic [3:0] FN_SLT   = 4'd5;
  localparam logic [3:0] FN_PASSA = 4'd6;
  localparam logic [3:0] FN_MOD   = 4'd7;

  state_t      state_q, state_d;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];
  logic        busy_q, busy_d;
  logic        zero_q, zero_d;
  logic        drop_q, drop_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic [3:0]  dst_q, dst_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [31:0] op_a, op_b, alu_res;
  logic [32:0] shifted, diff;

  assign op_a = rf_q[bus.raddr1];
  assign op_b = bus.alusrc ? bus.aluconst : rf_q[bus.raddr2];

  always_comb begin
    alu_res = '0;
    case (bus.func)
      FN_ADD:   alu_res = op_a + op_b;
      FN_SUB:   alu_res = op_a - op_b;
      FN_AND:   alu_res = op_a & op_b;
      FN_OR:    alu_res = op_a | op_b;
      FN_XOR:   alu_res = op_a ^ op_b;
      FN_SLT:   alu_res = {31'd0, op_a < op_b};
      FN_PASSA: alu_res = op_a;
      default:  alu_res = '0;
    endcase
  end

  // Restoring step: bring in the next dividend bit, subtract divisor when it fits.
  // A zero divisor always "fits", so the remainder simply accumulates A.
  assign shifted = {rem_q, dividend_q[31]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_comb begin
    rf_d       = rf_q;
    state_d    = state_q;
    busy_d     = busy_q;
    zero_d     = zero_q;
    drop_d     = bus.wen & busy_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.wen) begin
          if (!bus.wdsrc) begin
            rf_d[bus.waddr] = bus.constant;
          end else if (bus.func == FN_MOD) begin
            dividend_d = op_a;
            divisor_d  = op_b;
            rem_d      = '0;
            dst_d      = bus.waddr;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = DIV;
          end else begin
            rf_d[bus.waddr] = alu_res;
            zero_d          = (alu_res == 32'd0);
          end
        end
      end
      DIV: begin
        dividend_d = {dividend_q[30:0], 1'b0};
        rem_d      = (shifted >= {1'b0, divisor_q}) ? diff[31:0] : shifted[31:0];
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = WB;
      end
      WB: begin
        rf_d[dst_q] = rem_q;
        zero_d      = (rem_q == 32'd0);
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b0;
      drop_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      zero_q     <= zero_d;
      drop_q     <= drop_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.outrdata1 = rf_q[bus.raddr1];
  assign bus.outrdata2 = rf_q[bus.raddr2];
  assign bus.isZero    = zero_q;
  assign bus.busy      = busy_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_lcm_datapath.sv
// tb/tb_lcm_datapath.sv - directed self-checking bench for lcm_datapath
module tb_lcm_datapath;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcm_datapath_if bus ();
  lcm_datapath dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs;
    bus.wen = 1'b0; bus.wdsrc = 1'b0; bus.func = 4'd0; bus.waddr = 4'd0;
    bus.constant = 32'd0; bus.alusrc = 1'b0; bus.aluconst = 32'd0;
    bus.raddr1 = 4'd0; bus.raddr2 = 4'd0;
  endtask

  task automatic write_const(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.wen = 1'b1; bus.wdsrc = 1'b0; bus.waddr = a; bus.constant = v;
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic alu_write(input logic [3:0] f, input logic [3:0] ra1, input logic [3:0] ra2,
                           input logic [3:0] wa, input logic src, input logic [31:0] k);
    @(negedge clk);
    bus.wen = 1'b1; bus.wdsrc = 1'b1; bus.func = f; bus.raddr1 = ra1; bus.raddr2 = ra2;
    bus.waddr = wa; bus.alusrc = src; bus.aluconst = k;
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    bus.raddr1 = a;
    #1;
    v = bus.outrdata1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    bus.wen = 1'b1; bus.wdsrc = 1'b0; bus.waddr = 4'd0; bus.constant = 32'hDEAD;
    repeat (2) @(negedge clk);
    rst = 1'b0; bus.wen = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL reset_iszero got=%b exp=0", bus.isZero); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", bus.drop); end
    peek(4'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_rf0 got=%h exp=0", v); end
  endtask

  task automatic test_write_read;
    write_const(4'd0, 32'd4);
    write_const(4'd1, 32'd6);
    bus.raddr1 = 4'd0; bus.raddr2 = 4'd1;
    #1;
    checks++; if (bus.outrdata1 !== 32'd4) begin errors++; $display("FAIL rd1 got=%h exp=4", bus.outrdata1); end
    checks++; if (bus.outrdata2 !== 32'd6) begin errors++; $display("FAIL rd2 got=%h exp=6", bus.outrdata2); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL wr_iszero got=%b exp=0", bus.isZero); end
  endtask

  task automatic test_mod;
    int n;
    logic [31:0] v;
    write_const(4'd2, 32'd12);
    alu_write(4'd7, 4'd2, 4'd0, 4'd3, 1'b0, 32'd0);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL mod_latency got=%0d exp=33", n); end
    peek(4'd3, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL mod_12_4 got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL mod_12_4_z got=%b exp=1", bus.isZero); end
    alu_write(4'd7, 4'd2, 4'd1, 4'd4, 1'b0, 32'd0);
    wait_idle(n);
    peek(4'd4, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL mod_12_6 got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL mod_12_6_z got=%b exp=1", bus.isZero); end
    write_const(4'd2, 32'd13);
    alu_write(4'd7, 4'd2, 4'd1, 4'd6, 1'b0, 32'd0);
    wait_idle(n);
    peek(4'd6, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL mod_13_6 got=%h exp=1", v); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL mod_13_6_z got=%b exp=0", bus.isZero); end
  endtask

  task automatic test_alu;
    logic [31:0] v;
    write_const(4'd2, 32'hFFFF_FFFF);
    alu_write(4'd0, 4'd2, 4'd0, 4'd2, 1'b1, 32'd1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b exp=0", bus.busy); end
    peek(4'd2, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL add_wrap got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL add_wrap_z got=%b exp=1", bus.isZero); end
    alu_write(4'd1, 4'd0, 4'd1, 4'd7, 1'b0, 32'd0);
    peek(4'd7, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub got=%h exp=fffffffe", v); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL sub_z got=%b exp=0", bus.isZero); end
    alu_write(4'd5, 4'd0, 4'd1, 4'd8, 1'b0, 32'd0);
    peek(4'd8, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL slt_lt got=%h exp=1", v); end
    alu_write(4'd5, 4'd1, 4'd0, 4'd8, 1'b0, 32'd0);
    peek(4'd8, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL slt_ge got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL slt_ge_z got=%b exp=1", bus.isZero); end
    alu_write(4'd4, 4'd0, 4'd1, 4'd9, 1'b1, 32'h0000_00F0);
    peek(4'd9, v);
    checks++; if (v !== 32'h0000_00F4) begin errors++; $display("FAIL xor got=%h exp=f4", v); end
    alu_write(4'd9, 4'd0, 4'd1, 4'd10, 1'b0, 32'd0);
    peek(4'd10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reserved got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL reserved_z got=%b exp=1", bus.isZero); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    @(negedge clk);
    bus.wen = 1'b1; bus.wdsrc = 1'b0; bus.waddr = 4'd1; bus.constant = 32'd3;
    @(negedge clk);
    bus.wdsrc = 1'b1; bus.func = 4'd0; bus.raddr1 = 4'd1; bus.raddr2 = 4'd1;
    bus.alusrc = 1'b0; bus.waddr = 4'd11;
    @(negedge clk);
    bus.wen = 1'b0;
    peek(4'd11, v);
    checks++; if (v !== 32'd6) begin errors++; $display("FAIL b2b_add got=%h exp=6", v); end
  endtask

  task automatic test_drop;
    int n;
    logic [31:0] v;
    write_const(4'd0, 32'd40);
    write_const(4'd1, 32'd6);
    write_const(4'd5, 32'd0);
    alu_write(4'd7, 4'd0, 4'd1, 4'd8, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    bus.wen = 1'b1; bus.wdsrc = 1'b0; bus.waddr = 4'd5; bus.constant = 32'd7;
    @(negedge clk);
    bus.wen = 1'b0;
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", bus.drop); end
    @(negedge clk);
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL drop_once got=%b exp=0", bus.drop); end
    peek(4'd5, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL drop_rf5 got=%h exp=0", v); end
    wait_idle(n);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_timeout busy=%b exp=0", bus.busy); end
    bus.wen = 1'b1; bus.wdsrc = 1'b0; bus.waddr = 4'd5; bus.constant = 32'd7;
    @(negedge clk);
    bus.wen = 1'b0;
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL retry_drop got=%b exp=0", bus.drop); end
    peek(4'd5, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL retry_rf5 got=%h exp=7", v); end
    peek(4'd8, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL mod_40_6 got=%h exp=4", v); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL mod_40_6_z got=%b exp=0", bus.isZero); end
  endtask

  task automatic test_mod_edge;
    int n;
    logic [31:0] v;
    write_const(4'd9, 32'd100);
    write_const(4'd10, 32'd0);
    write_const(4'd12, 32'd5);
    write_const(4'd13, 32'd9);
    alu_write(4'd7, 4'd9, 4'd10, 4'd14, 1'b0, 32'd0);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL div0_latency got=%0d exp=33", n); end
    peek(4'd14, v);
    checks++; if (v !== 32'd100) begin errors++; $display("FAIL div0 got=%h exp=64", v); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL div0_z got=%b exp=0", bus.isZero); end
    alu_write(4'd7, 4'd12, 4'd13, 4'd15, 1'b0, 32'd0);
    wait_idle(n);
    peek(4'd15, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL mod_5_9 got=%h exp=5", v); end
    alu_write(4'd7, 4'd9, 4'd0, 4'd3, 1'b1, 32'd7);
    wait_idle(n);
    peek(4'd3, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL mod_100_k7 got=%h exp=2", v); end
    alu_write(4'd7, 4'd13, 4'd13, 4'd4, 1'b0, 32'd0);
    wait_idle(n);
    peek(4'd4, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL mod_eq got=%h exp=0", v); end
    checks++; if (bus.isZero !== 1'b1) begin errors++; $display("FAIL mod_eq_z got=%b exp=1", bus.isZero); end
  endtask

  task automatic test_reset_mid_mod;
    logic [31:0] v;
    alu_write(4'd7, 4'd9, 4'd13, 4'd7, 1'b0, 32'd0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    repeat (25) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_late got=%b exp=0", bus.busy); end
    checks++; if (bus.isZero !== 1'b0) begin errors++; $display("FAIL rstmid_iszero got=%b exp=0", bus.isZero); end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL rstmid_rf%0d got=%h exp=0", i, v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_mod();
    test_alu();
    test_back_to_back();
    test_drop();
    test_mod_edge();
    test_reset_mid_mod();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcm_datapath.md
LCM_DATAPATH -- requirements
Module: lcm_datapath

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 raddr1  input  4  register-file read port 1 address (ALU operand A).
REQ-004 raddr2  input  4  register-file read port 2 address (ALU operand B when alusrc=0).
REQ-005 wen  input  1  write command strobe, sampled every cycle.
REQ-006 waddr  input  4  destination register of the write command.
REQ-007 wdsrc  input  1  write-data select: 0 = constant, 1 = ALU result.
REQ-008 func  input  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (unsigned), 6 PASSA, 7 MOD; 8-15 reserved, result 0.
REQ-009 constant  input  32  immediate write data when wdsrc=0.
REQ-010 alusrc  input  1  operand-B select: 0 = rf[raddr2], 1 = aluconst.
REQ-011 aluconst  input  32  immediate ALU operand B.
REQ-012 outrdata1  output  32  combinational rf[raddr1].
REQ-013 outrdata2  output  32  combinational rf[raddr2].
REQ-014 isZero  output  1  registered flag, result of the last ALU write was zero.
REQ-015 busy  output  1  registered, high while a MOD is in progress.
REQ-016 drop  output  1  registered one-cycle pulse, a wen command was ignored because busy=1.

Function
REQ-017 Register file: 16 x 32-bit, reads combinational, write on rising edge; register 0 is an ordinary writable register.
REQ-018 Operand A = rf[raddr1]; operand B = aluconst if alusrc=1, else rf[raddr2]; all arithmetic unsigned 32-bit, ADD/SUB wrap modulo 2^32, no carry out.
REQ-019 Command accepted when wen=1 and busy=0; wen=1 with busy=1 -> no write, no state change, drop=1 on next cycle.
REQ-020 Accepted wdsrc=0 -> rf[waddr]=constant at that edge; isZero unchanged.
REQ-021 Accepted wdsrc=1, func!=MOD -> rf[waddr]=ALU result at that edge; isZero=(result==0) at same edge.
REQ-022 Accepted wdsrc=1, func=MOD -> A, B, waddr captured at edge E0; busy=1 from E0; restoring shift-subtract divider, one quotient bit per cycle, 32 iterations E1..E32; remainder written to captured waddr and isZero updated at edge E33; busy=0 after E33.
REQ-023 MOD latency fixed at 33 cycles, independent of operand values.
REQ-024 MOD with B=0 -> remainder = A, still 33 cycles, no error indication.
REQ-025 MOD with A<B -> remainder = A; A=B -> 0.
REQ-026 Operand capture at E0 makes MOD result immune to rf writes or address/input changes during busy.
REQ-027 FSM states: IDLE (busy=0) -> DIV on accepted MOD; DIV counts 32 iterations -> WB; WB writes remainder -> IDLE; no other transitions except reset.
REQ-028 Command presented in the cycle busy falls to 0 (first cycle after E33) is accepted normally.
REQ-029 wen=0 -> no write, isZero and rf hold.
REQ-030 Reserved func with wdsrc=1 -> writes 0, isZero=1.

Reset
REQ-031 rst=1 at an edge: all 16 registers=0, isZero=0, busy=0, drop=0, FSM=IDLE, divider state cleared; takes priority over any command.
REQ-032 rst asserted mid-MOD aborts the division; no remainder write occurs.
REQ-033 Commands presented in the rst cycle are ignored.

Verification
REQ-034 Write rf0=4, rf1=6 (wdsrc=0), read raddr1=0, raddr2=1 -> outrdata1=4, outrdata2=6 next cycle, isZero=0.
REQ-035 rf2=12, MOD raddr1=2 raddr2=0 waddr=3 -> busy high 33 cycles, rf3=0, isZero=1 after E33; repeat with raddr2=1 (12 mod 6) -> rf4=0, isZero=1; 13 mod 6 -> 1, isZero=0.
REQ-036 ADD raddr1=2, alusrc=1, aluconst=1, waddr=2 with rf2=0xFFFFFFFF -> rf2=0, isZero=1, busy never asserted.
REQ-037 MOD in progress, wen=1 writing constant 7 to rf5 at E10 -> drop pulse, rf5 unchanged; same command first cycle after busy falls -> rf5=7.
REQ-038 MOD 100 mod 0 -> rf[waddr]=100 after 33 cycles, isZero=0; MOD 5 mod 9 -> 5.
REQ-039 rst at E15 of a MOD -> busy=0, all registers 0, no write at former E33.
